// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives program memory and loads IF/ID.
// Redirects beat stalls; an illegal fetch address parks the stage in HALT.
module fetch_stage #(
  parameter int MEMORY_DEPTH = 2048,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  jr,
  input  logic [DATA_WIDTH-1:0] jr_target,
  input  logic [DATA_WIDTH-1:0] instruction_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
  output logic                  if_id_valid,
  output logic                  fetch_fault
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [DATA_WIDTH-1:0] LIMIT =
    DATA_WIDTH'(4 * MEMORY_DEPTH);

  state_t                state;
  logic                  redirect;
  logic                  legal;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] offset;

  assign redirect = jr | jump | branch_taken;
  assign pc_plus4 = pc_o + DATA_WIDTH'(4);
  assign offset = pc_o - TEXT_BASE;
  assign legal = (pc_o[1:0] == 2'b00) && (offset < LIMIT);

  // jr outranks jump, which outranks branch
  always_comb begin
    target = branch_target;
    if (jump) target = jump_target;
    if (jr) target = jr_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      pc_o              <= TEXT_BASE;
      if_id_instruction <= '0;
      if_id_pc_plus4    <= '0;
      if_id_valid       <= 1'b0;
      fetch_fault       <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (redirect) begin
            pc_o              <= target;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
          end else if (!legal) begin
            state             <= HALT;
            fetch_fault       <= 1'b1;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
          end else if (stall) begin
            if (flush) begin
              if_id_instruction <= '0;
              if_id_pc_plus4    <= '0;
              if_id_valid       <= 1'b0;
            end
          end else if (flush) begin
            pc_o              <= pc_plus4;
            if_id_instruction <= '0;
            if_id_pc_plus4    <= '0;
            if_id_valid       <= 1'b0;
          end else begin
            pc_o              <= pc_plus4;
            if_id_instruction <= instruction_i;
            if_id_pc_plus4    <= pc_plus4;
            if_id_valid       <= 1'b1;
          end
        end
        HALT: begin
          fetch_fault       <= 1'b1;
          if_id_instruction <= '0;
          if_id_pc_plus4    <= '0;
          if_id_valid       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queued expectation scoreboard.
// A small program-memory model answers pc_o combinationally.
module tb_fetch_stage;

  localparam logic [31:0] BASE = 32'h0040_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, branch_taken, jump, jr;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] instruction_i;
  logic [31:0] pc_o, if_id_instruction, if_id_pc_plus4;
  logic        if_id_valid, fetch_fault;

  int   n_assert = 0;
  int   n_fail = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .jr(jr),
    .jr_target(jr_target),
    .instruction_i(instruction_i),
    .pc_o(pc_o),
    .if_id_instruction(if_id_instruction),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == BASE) return 32'h2008_0005;
    if (a == BASE + 32'd4) return 32'h2009_0003;
    return {16'h3C00, a[15:0]};
  endfunction

  assign instruction_i = mem(pc_o);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".pc"}, pc_o, e.pc);
    chk({tag, ".instr"}, if_id_instruction, e.instr);
    chk({tag, ".pc4"}, if_id_pc_plus4, e.pc4);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, e.valid});
    chk({tag, ".fault"}, {31'b0, fetch_fault}, {31'b0, e.fault});
  endtask

  task automatic step(
    input string tag,
    input logic st, input logic fl,
    input logic br, input logic [31:0] bt,
    input logic jm, input logic [31:0] jt,
    input logic j, input logic [31:0] jrt,
    input logic [31:0] e_pc, input logic [31:0] e_ins,
    input logic [31:0] e_pc4, input logic e_v, input logic e_f
  );
    exp_t e, got;
    stall = st; flush = fl;
    branch_taken = br; branch_target = bt;
    jump = jm; jump_target = jt;
    jr = j; jr_target = jrt;
    e.pc = e_pc; e.instr = e_ins; e.pc4 = e_pc4;
    e.valid = e_v; e.fault = e_f;
    q.push_back(e);
    @(posedge clk);
    #1;
    got = q.pop_front();
    check_all(tag, got);
  endtask

  function automatic exp_t rst_vals();
    exp_t e;
    e.pc = BASE; e.instr = 0; e.pc4 = 0;
    e.valid = 0; e.fault = 0;
    return e;
  endfunction

  initial begin
    reset = 1'b1;
    {stall, flush, branch_taken, jump, jr} = '0;
    branch_target = 0; jump_target = 0; jr_target = 0;
    #2;
    check_all("reset", rst_vals());
    @(posedge clk);
    #1 reset = 1'b0;

    step("seq0", 0,0, 0,0, 0,0, 0,0,
         BASE+4, 32'h2008_0005, BASE+4, 1, 0);
    step("seq1", 0,0, 0,0, 0,0, 0,0,
         BASE+8, 32'h2009_0003, BASE+8, 1, 0);
    step("stall0", 1,0, 0,0, 0,0, 0,0,
         BASE+8, 32'h2009_0003, BASE+8, 1, 0);
    step("stall1", 1,0, 0,0, 0,0, 0,0,
         BASE+8, 32'h2009_0003, BASE+8, 1, 0);
    step("stallfl", 1,1, 0,0, 0,0, 0,0,
         BASE+8, 0, 0, 0, 0);
    step("brjmp", 1,0, 1,32'h0040_0020, 1,32'h0040_0100, 0,0,
         32'h0040_0100, 0, 0, 0, 0);
    step("aftjmp", 0,0, 0,0, 0,0, 0,0,
         32'h0040_0104, mem(32'h0040_0100), 32'h0040_0104, 1, 0);
    step("flush", 0,1, 0,0, 0,0, 0,0,
         32'h0040_0108, 0, 0, 0, 0);
    step("jr", 0,0, 0,0, 0,0, 1,32'h0040_0012,
         32'h0040_0012, 0, 0, 0, 0);
    step("fault", 0,0, 0,0, 0,0, 0,0,
         32'h0040_0012, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step("halt", 1'($urandom_range(1)), 1'($urandom_range(1)),
           0,0, 1'($urandom_range(1)), BASE, 0,0,
           32'h0040_0012, 0, 0, 0, 1);
    end

    #3 reset = 1'b1;
    #1 check_all("async_rst", rst_vals());
    @(posedge clk);
    #1 check_all("rst_hold", rst_vals());
    reset = 1'b0;

    step("resume", 0,0, 0,0, 0,0, 0,0,
         BASE+4, 32'h2008_0005, BASE+4, 1, 0);
    step("branch", 0,1, 1,32'h0040_0020, 0,0, 0,0,
         32'h0040_0020, 0, 0, 0, 0);
    step("jr_prio", 0,0, 1,32'h0040_0030, 1,32'h0040_0200,
         1,32'h0040_1FF8,
         32'h0040_1FF8, 0, 0, 0, 0);
    step("last-1", 0,0, 0,0, 0,0, 0,0,
         32'h0040_1FFC, mem(32'h0040_1FF8), 32'h0040_1FFC, 1, 0);
    step("last", 0,0, 0,0, 0,0, 0,0,
         32'h0040_2000, mem(32'h0040_1FFC), 32'h0040_2000, 1, 0);
    step("oob", 0,0, 0,0, 0,0, 0,0,
         32'h0040_2000, 0, 0, 0, 1);

    n_assert++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_empty observed=%0d expected=0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter and drives the program-memory address; the program memory returns the instruction combinationally in the same cycle.
- Registers the fetched instruction and PC+4 into the IF/ID pipeline register.
- Handles stalls, flushes, branch/jump/jr redirects, and halts on an illegal fetch address.

Parameters:
MEMORY_DEPTH, 2048, program-memory depth in 32-bit words
DATA_WIDTH, 32, instruction/address width
TEXT_BASE, 32'h0040_0000, reset PC and first word of program memory

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  hazard unit: load a bubble into IF/ID
branch_taken  input  1  resolved taken branch
branch_target  input  DATA_WIDTH  branch target address
jump  input  1  j/jal redirect
jump_target  input  DATA_WIDTH  jump target address
jr  input  1  jr/jalr redirect
jr_target  input  DATA_WIDTH  register target address
instruction_i  input  DATA_WIDTH  instruction returned by program memory for pc_o
pc_o  output  DATA_WIDTH  current PC, drives program-memory address
if_id_instruction  output  DATA_WIDTH  IF/ID instruction
if_id_pc_plus4  output  DATA_WIDTH  IF/ID PC+4 for link and branch
if_id_valid  output  1  IF/ID holds a real instruction
fetch_fault  output  1  sticky illegal-fetch flag

Behaviour:
- Reset values (async):
  - pc_o = TEXT_BASE
  - if_id_instruction = 0 (NOP)
  - if_id_pc_plus4 = 0
  - if_id_valid = 0
  - fetch_fault = 0
  - state = RUN
- Legal PC: pc[1:0]==0 and (pc - TEXT_BASE), as unsigned 32-bit, < 4*MEMORY_DEPTH.
- States:
  - RUN: normal fetch.
  - HALT: fetch_fault=1, pc_o frozen, IF/ID loaded with bubble every cycle. Exit only via reset.
- RUN, per rising edge, first matching rule applies:
  1. Redirect (jr | jump | branch_taken). Target priority: jr > jump > branch.
     - pc_o <= selected target.
     - IF/ID <= bubble (instruction 0, pc_plus4 0, valid 0).
     - A redirect overrides stall and flush.
  2. Current pc_o illegal.
     - state <= HALT, fetch_fault <= 1.
     - IF/ID <= bubble, pc_o held.
  3. stall, with flush also asserted.
     - pc_o held, IF/ID <= bubble.
  4. stall alone.
     - pc_o held, IF/ID held unchanged.
  5. flush alone.
     - pc_o <= pc_o+4, IF/ID <= bubble.
  6. Otherwise.
     - pc_o <= pc_o+4.
     - IF/ID <= {instruction_i, pc_o+4, valid 1}.
- An illegal redirect target is accepted into pc_o. The fault is detected on the following edge (rule 2), so the illegal word never enters IF/ID with valid=1.
- Fetch latency: the instruction at pc_o appears at IF/ID one edge later.
- The redirect penalty is exactly one bubble.
- PC+4 arithmetic is modulo 2^32, no carry out; wrap-around yields an illegal PC and therefore HALT.
- Reset asserted mid-operation, including in HALT, returns to the reset values immediately. Fetch resumes at TEXT_BASE on the first edge after reset deasserts.

Test Plan:
- Reset, then memory words {0x2008_0005, 0x2009_0003, ...} -> pc_o goes 0x0040_0000, 0x0040_0004, 0x0040_0008. IF/ID shows 0x2008_0005 with pc_plus4 0x0040_0004 and valid 1 after edge 1, then 0x2009_0003 with pc_plus4 0x0040_0008.
- stall held 2 cycles at pc 0x0040_0008 -> pc_o and IF/ID unchanged for 2 edges. stall+flush for 1 cycle -> pc held, valid 0.
- branch_taken=1 (target 0x0040_0020) with jump=1 (target 0x0040_0100) and stall=1, same cycle -> pc_o=0x0040_0100, valid 0. Next edge fetches from 0x0040_0100 with pc_plus4 0x0040_0104.
- jr=1, jr_target=0x0040_0012 -> pc_o=0x0040_0012, then fetch_fault=1. pc_o frozen and valid stays 0 for 10 further cycles regardless of stall/flush/jump.
- Sequential fetch to last word 0x0040_1FFC (DEPTH 2048) -> that word is fetched valid, then pc 0x0040_2000 triggers fetch_fault=1 with no valid instruction.
- Assert reset asynchronously mid-cycle while in HALT -> all outputs take reset values immediately without a clock edge. Normal fetch resumes at 0x0040_0000.
